// File: rtl/seq_code_tracker.sv
// seq_code_tracker: receive-side tracker for the 14-state permuted 4-bit
// sequence counter. Decodes each sampled code to its index 0..13, checks it
// against the previously accepted index, acquires and holds lock, and reports
// sequence errors, wraps and restarts. All outputs are registered.
module seq_code_tracker #(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 code_valid,
    input  logic [3:0]           code_in,
    output logic [3:0]           index_out,
    output logic                 index_valid,
    output logic                 locked,
    output logic                 seq_error,
    output logic                 wrap,
    output logic                 restart,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_index;
    logic                 r_index_valid;
    logic                 r_locked;
    logic                 r_seq_error;
    logic                 r_wrap;
    logic                 r_restart;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [3:0]           r_match;
    logic [3:0]           r_miss;

    logic                 w_dec_ok;
    logic [3:0]           w_dec_idx;
    logic [3:0]           w_next_idx;
    logic                 w_is_adv;
    logic                 w_is_hold;
    logic                 w_is_rst;

    // Decode the permuted code back to its sequence index; codes 0 and 10 never occur.
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_idx = 4'd0;
        case (code_in)
            4'd8:    w_dec_idx = 4'd0;
            4'd7:    w_dec_idx = 4'd1;
            4'd11:   w_dec_idx = 4'd2;
            4'd4:    w_dec_idx = 4'd3;
            4'd9:    w_dec_idx = 4'd4;
            4'd2:    w_dec_idx = 4'd5;
            4'd5:    w_dec_idx = 4'd6;
            4'd12:   w_dec_idx = 4'd7;
            4'd6:    w_dec_idx = 4'd8;
            4'd3:    w_dec_idx = 4'd9;
            4'd15:   w_dec_idx = 4'd10;
            4'd1:    w_dec_idx = 4'd11;
            4'd14:   w_dec_idx = 4'd12;
            4'd13:   w_dec_idx = 4'd13;
            default: w_dec_ok  = 1'b0;
        endcase
    end

    // Classify the incoming index against the stored one (advance / hold / restart).
    always_comb begin
        w_next_idx = (r_index == 4'd13) ? 4'd0 : r_index + 4'd1;
        w_is_adv   = w_dec_ok && (w_dec_idx == w_next_idx);
        w_is_hold  = w_dec_ok && (w_dec_idx == r_index);
        w_is_rst   = w_dec_ok && (w_dec_idx == 4'd0) &&
                     (r_index != 4'd0) && (r_index != 4'd13);
    end

    // Tracker FSM: hunt for a decodable code, verify advances, hold lock until misses accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_HUNT;
            r_index       <= 4'd0;
            r_index_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_seq_error   <= 1'b0;
            r_wrap        <= 1'b0;
            r_restart     <= 1'b0;
            r_err_count   <= '0;
            r_match       <= 4'd0;
            r_miss        <= 4'd0;
        end else begin
            r_seq_error <= 1'b0;
            r_wrap      <= 1'b0;
            r_restart   <= 1'b0;
            if (code_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_dec_ok) begin
                            r_index       <= w_dec_idx;
                            r_index_valid <= 1'b1;
                            r_match       <= 4'd1;
                            if (LOCK_COUNT == 1) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (!w_dec_ok) begin
                            r_state       <= ST_HUNT;
                            r_index_valid <= 1'b0;
                            r_match       <= 4'd0;
                        end else if (w_is_adv) begin
                            r_index <= w_dec_idx;
                            r_wrap  <= (r_index == 4'd13);
                            // match counts the anchoring code too, so lock is taken on the
                            // advance seen while match already equals LOCK_COUNT.
                            if (r_match == 4'(LOCK_COUNT)) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_match  <= r_match + 4'd1;
                            end
                        end else if (!w_is_hold) begin
                            // Restart or out-of-sequence code: re-anchor on the new index.
                            r_index   <= w_dec_idx;
                            r_match   <= 4'd1;
                            r_restart <= w_is_rst;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_is_adv || w_is_hold || w_is_rst) begin
                            r_miss    <= 4'd0;
                            r_index   <= w_dec_idx;
                            r_wrap    <= w_is_adv && (r_index == 4'd13);
                            r_restart <= w_is_rst;
                        end else begin
                            r_seq_error <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (w_dec_ok) begin
                                r_index <= w_dec_idx;
                            end
                            if (r_miss == 4'(UNLOCK_COUNT - 1)) begin
                                r_state       <= ST_HUNT;
                                r_locked      <= 1'b0;
                                r_index_valid <= 1'b0;
                                r_miss        <= 4'd0;
                            end else begin
                                r_miss <= r_miss + 4'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign index_out   = r_index;
    assign index_valid = r_index_valid;
    assign locked      = r_locked;
    assign seq_error   = r_seq_error;
    assign wrap        = r_wrap;
    assign restart     = r_restart;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_seq_code_tracker.sv
// Testbench for seq_code_tracker: two instances (default parameters and a
// LOCK_COUNT=1 / UNLOCK_COUNT=15 / ERR_CNT_W=2 variant) share one stimulus
// stream; a reference model queues expected outputs, a monitor compares them.
module tb_seq_code_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [3:0] code_in = 4'd0;

    logic [3:0] a_idx, b_idx;
    logic       a_iv, a_lk, a_se, a_wr, a_rs;
    logic       b_iv, b_lk, b_se, b_wr, b_rs;
    logic [7:0] a_err;
    logic [1:0] b_err;

    always #5 clk = ~clk;

    seq_code_tracker #(.LOCK_COUNT(3), .UNLOCK_COUNT(2), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .index_out(a_idx), .index_valid(a_iv), .locked(a_lk), .seq_error(a_se),
        .wrap(a_wr), .restart(a_rs), .err_count(a_err)
    );

    seq_code_tracker #(.LOCK_COUNT(1), .UNLOCK_COUNT(15), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .index_out(b_idx), .index_valid(b_iv), .locked(b_lk), .seq_error(b_se),
        .wrap(b_wr), .restart(b_rs), .err_count(b_err)
    );

    // Reference model: mode 0 hunting, 1 verifying, 2 locked.
    typedef struct {
        int mode; int p; bit iv; int match; int miss; int err;
        bit serr; bit wr; bit rs;
    } mstate_t;

    typedef struct {
        int idx; bit iv; bit lk; bit se; bit wr; bit rs; int err;
    } exp_t;

    int enc[14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

    mstate_t ma, mb;
    exp_t    qa[$], qb[$];
    int      vectors = 0;
    int      miscompares = 0;
    int      tx = 0;

    function automatic int decode(input int c);
        for (int i = 0; i < 14; i++) if (enc[i] == c) return i;
        return -1;
    endfunction

    function automatic void mstep(inout mstate_t s, input bit r, input bit v,
                                  input int c, input int lc, input int uc, input int emax);
        int d;
        int nxt;
        s.serr = 0; s.wr = 0; s.rs = 0;
        if (r) begin
            s.mode = 0; s.p = 0; s.iv = 0; s.match = 0; s.miss = 0; s.err = 0;
            return;
        end
        if (!v) return;
        d   = decode(c);
        nxt = (s.p + 1) % 14;
        if (s.mode == 0) begin
            if (d >= 0) begin
                s.p = d; s.iv = 1; s.match = 1;
                s.mode = (lc == 1) ? 2 : 1;
            end
        end else if (s.mode == 1) begin
            if (d < 0) begin
                s.mode = 0; s.iv = 0; s.match = 0;
            end else if (d == nxt) begin
                s.wr = (s.p == 13);
                s.p = d;
                if (s.match == lc) s.mode = 2;
                else s.match++;
            end else if (d == s.p) begin
                // hold
            end else begin
                s.rs = (d == 0);
                s.p = d; s.match = 1;
            end
        end else begin
            if (d >= 0 && (d == nxt || d == s.p || d == 0)) begin
                s.wr = (d == nxt) && (s.p == 13);
                s.rs = (d == 0) && (d != nxt) && (d != s.p);
                s.p = d; s.miss = 0;
            end else begin
                s.serr = 1;
                if (s.err < emax) s.err++;
                if (d >= 0) s.p = d;
                s.miss++;
                if (s.miss == uc) begin
                    s.mode = 0; s.iv = 0; s.miss = 0;
                end
            end
        end
    endfunction

    function automatic exp_t expof(input mstate_t s);
        exp_t e;
        e.idx = s.p; e.iv = s.iv; e.lk = (s.mode == 2);
        e.se = s.serr; e.wr = s.wr; e.rs = s.rs; e.err = s.err;
        return e;
    endfunction

    task automatic drive(input bit r, input bit v, input int c);
        @(negedge clk);
        reset = r; code_valid = v; code_in = 4'(c);
        mstep(ma, r, v, c, 3, 2, 255);
        qa.push_back(expof(ma));
        mstep(mb, r, v, c, 1, 15, 3);
        qb.push_back(expof(mb));
    endtask

    task automatic send(input int c);
        drive(0, 1, c);
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a registered result every cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("A.index_out",   int'(a_idx), e.idx);
                cmp("A.index_valid", int'(a_iv),  int'(e.iv));
                cmp("A.locked",      int'(a_lk),  int'(e.lk));
                cmp("A.seq_error",   int'(a_se),  int'(e.se));
                cmp("A.wrap",        int'(a_wr),  int'(e.wr));
                cmp("A.restart",     int'(a_rs),  int'(e.rs));
                cmp("A.err_count",   int'(a_err), e.err);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("B.index_out",   int'(b_idx), e.idx);
                cmp("B.index_valid", int'(b_iv),  int'(e.iv));
                cmp("B.locked",      int'(b_lk),  int'(e.lk));
                cmp("B.seq_error",   int'(b_se),  int'(e.se));
                cmp("B.wrap",        int'(b_wr),  int'(e.wr));
                cmp("B.restart",     int'(b_rs),  int'(e.rs));
                cmp("B.err_count",   int'(b_err), e.err);
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized transmitter with faults.
    initial begin
        int r;
        int r2;
        int c;
        int d;
        ma = '{default: 0};
        mb = '{default: 0};

        drive(1, 1, 8);
        foreach (enc[i]) if (i <= 3) send(enc[i]);          // acquire lock at index 3
        for (int i = 4; i < 14; i++) send(enc[i]);          // run up to 13
        send(8);                                            // wrap 13 -> 0
        for (int i = 1; i <= 5; i++) send(enc[i]);          // index 5
        repeat (4) send(2);                                 // hold
        send(8);                                            // restart
        for (int i = 1; i <= 3; i++) send(enc[i]);          // index 3
        send(10);
        send(0);                                            // two invalid codes
        drive(0, 0, 0);
        drive(1, 0, 0);
        foreach (enc[i]) if (i <= 3) send(enc[i]);
        send(5);                                            // bad, re-base to 6
        send(12);                                           // advance to 7
        repeat (5) send(10);                                // saturation on narrow counter
        drive(1, 1, 7);                                     // reset mid-stream
        drive(0, 0, 0);

        tx = 0;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1, $urandom_range(0, 1), $urandom_range(0, 15));
                tx = 0;
            end else if (r < 12) begin
                drive(0, 0, $urandom_range(0, 15));
            end else begin
                r2 = $urandom_range(0, 99);
                if (r2 < 65) begin
                    tx = (tx + 1) % 14; c = enc[tx];
                end else if (r2 < 75) begin
                    c = enc[tx];
                end else if (r2 < 82) begin
                    tx = 0; c = enc[0];
                end else if (r2 < 93) begin
                    c = $urandom_range(0, 15);
                    d = decode(c);
                    if (d >= 0) tx = d;
                end else begin
                    c = ($urandom_range(0, 1) == 1) ? 10 : 0;
                end
                send(c);
            end
        end

        drive(0, 0, 0);
        repeat (3) @(negedge clk);
        cmp("A.queue_drained", qa.size(), 0);
        cmp("B.queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
